// File: rtl/clk_div_gen_if.sv
// Configuration bus for clk_div_gen: write strobe, channel select and
// per-channel divide/phase values, with the acknowledge/error response.
interface clk_div_gen_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_phase;
    logic             cfg_ack;
    logic             cfg_err;

    modport master (
        output cfg_we, cfg_ch, cfg_div, cfg_phase,
        input  cfg_ack, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div, cfg_phase,
        output cfg_ack, cfg_err
    );
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider: each channel produces a registered
// 50% duty divided clock with a start delay, plus a global settle/lock indicator.
module clk_div_gen #(
    parameter int                          NUM_CH      = 4,
    parameter int                          CNT_W       = 8,
    parameter int                          LOCK_CYCLES = 16,
    parameter logic [NUM_CH*CNT_W-1:0]     INIT_DIV    = {8'd4, 8'd2, 8'd1, 8'd1},
    parameter logic [NUM_CH*CNT_W-1:0]     INIT_PHASE  = {8'd0, 8'd0, 8'd1, 8'd0}
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    clk_div_gen_if.slave      cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] clk_en,
    output logic              locked
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LCW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_DELAY = 2'd1;
    localparam logic [1:0] MODE_RUN   = 2'd2;

    localparam logic [0:0] ST_SETTLE  = 1'b0;
    localparam logic [0:0] ST_LOCKED  = 1'b1;

    function automatic logic [1:0] start_mode(input logic [CNT_W-1:0] d,
                                              input logic [CNT_W-1:0] p);
        if (d == CNT_W'(0)) begin
            return MODE_OFF;
        end else if (p != CNT_W'(0)) begin
            return MODE_DELAY;
        end else begin
            return MODE_RUN;
        end
    endfunction

    logic           wr_valid_s;
    logic           cfg_ack_r;
    logic           cfg_err_r;
    logic [0:0]     state_r;
    logic [LCW-1:0] lock_cnt_r;
    logic           locked_r;

    assign wr_valid_s  = cfg.cfg_we && (int'(cfg.cfg_ch) < NUM_CH);
    assign cfg.cfg_ack = cfg_ack_r;
    assign cfg.cfg_err = cfg_err_r;
    assign locked      = locked_r;

    // Write response: ack for every strobe, err when the channel index is out of range.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cfg_ack_r <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_ack_r <= cfg.cfg_we;
            cfg_err_r <= cfg.cfg_we && !wr_valid_s;
        end
    end

    // Lock FSM: any accepted write restarts the settle count from zero.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r    <= ST_SETTLE;
            lock_cnt_r <= LCW'(0);
            locked_r   <= 1'b0;
        end else if (wr_valid_s) begin
            state_r    <= ST_SETTLE;
            lock_cnt_r <= LCW'(0);
            locked_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_SETTLE: begin
                    if (lock_cnt_r == LOCK_LAST) begin
                        state_r  <= ST_LOCKED;
                        locked_r <= 1'b1;
                    end else begin
                        lock_cnt_r <= lock_cnt_r + LCW'(1);
                        locked_r   <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    locked_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_SETTLE;
                    lock_cnt_r <= LCW'(0);
                    locked_r   <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             hit_s;
        logic [CNT_W-1:0] div_r;
        logic [CNT_W-1:0] phase_r;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] dly_r;
        logic [1:0]       mode_r;
        logic             out_r;
        logic             en_r;

        assign hit_s      = wr_valid_s && (cfg.cfg_ch == CH_W'(i));
        assign clk_out[i] = out_r;
        assign clk_en[i]  = en_r;

        // Channel engine: reset/write reload and restart, otherwise delay then divide.
        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) begin
                div_r   <= INIT_DIV[i*CNT_W +: CNT_W];
                phase_r <= INIT_PHASE[i*CNT_W +: CNT_W];
                cnt_r   <= CNT_W'(0);
                dly_r   <= INIT_PHASE[i*CNT_W +: CNT_W];
                mode_r  <= start_mode(INIT_DIV[i*CNT_W +: CNT_W], INIT_PHASE[i*CNT_W +: CNT_W]);
                out_r   <= 1'b0;
                en_r    <= 1'b0;
            end else if (hit_s) begin
                div_r   <= cfg.cfg_div;
                phase_r <= cfg.cfg_phase;
                cnt_r   <= CNT_W'(0);
                dly_r   <= cfg.cfg_phase;
                mode_r  <= start_mode(cfg.cfg_div, cfg.cfg_phase);
                out_r   <= 1'b0;
                en_r    <= 1'b0;
            end else begin
                en_r <= 1'b0;
                case (mode_r)
                    MODE_DELAY: begin
                        dly_r <= dly_r - CNT_W'(1);
                        if (dly_r == CNT_W'(1)) begin
                            mode_r <= MODE_RUN;
                        end else begin
                            mode_r <= MODE_DELAY;
                        end
                    end
                    MODE_RUN: begin
                        if (cnt_r == div_r - CNT_W'(1)) begin
                            cnt_r <= CNT_W'(0);
                            out_r <= ~out_r;
                            en_r  <= ~out_r;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        out_r <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: table of power-up vectors plus hand-written
// sequences for reconfiguration, disable, lock restart and out-of-range writes.
module tb_clk_div_gen;
    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       sys_rst_n;
    logic [3:0] clk_out, clk_en;
    logic       locked;
    logic [2:0] clk_out3, clk_en3;
    logic       locked3;

    clk_div_gen_if #(.NUM_CH(4), .CNT_W(8)) cfg_bus ();
    clk_div_gen_if #(.NUM_CH(3), .CNT_W(8)) cfg_bus3 ();

    clk_div_gen dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg(cfg_bus),
        .clk_out(clk_out), .clk_en(clk_en), .locked(locked)
    );

    clk_div_gen #(
        .NUM_CH(3), .CNT_W(8), .LOCK_CYCLES(16),
        .INIT_DIV({8'd2, 8'd1, 8'd1}), .INIT_PHASE({8'd0, 8'd1, 8'd0})
    ) dut3 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg(cfg_bus3),
        .clk_out(clk_out3), .clk_en(clk_en3), .locked(locked3)
    );

    typedef struct {
        logic       rst_n;
        logic       we;
        logic [1:0] ch;
        logic [7:0] div;
        logic [7:0] phase;
        logic [3:0] exp_out;
        logic [3:0] exp_en;
        logic       exp_ack;
        logic       exp_locked;
    } vec_t;

    vec_t tbl [9];
    int   passed = 0;
    int   total  = 0;
    int   k      = 0;
    int   w_edge = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
    endtask

    // k counts rising edges since the last edge sampled in reset.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (!sys_rst_n) k = 0;
        else k++;
    endtask

    function automatic logic [3:0] exp_init(input int kk);
        logic [3:0] e;
        e[0] = (kk % 2) == 1;
        e[1] = (kk >= 2) && ((kk % 2) == 0);
        e[2] = (kk % 4) >= 2;
        e[3] = (kk % 8) >= 4;
        return e;
    endfunction

    // ch2 after div=3 phase=2 write: low for 5 readings, then period 6.
    function automatic logic exp_ch2(input int r);
        return (r >= 5) && (((r - 5) % 6) < 3);
    endfunction

    task automatic write_main(input logic [1:0] ch, input logic [7:0] dv, input logic [7:0] ph);
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_ch = ch; cfg_bus.cfg_div = dv; cfg_bus.cfg_phase = ph;
        tick();
        cfg_bus.cfg_we = 1'b0;
    endtask

    task automatic apply_table();
        for (int i = 0; i < 9; i++) begin
            sys_rst_n         = tbl[i].rst_n;
            cfg_bus.cfg_we    = tbl[i].we;
            cfg_bus.cfg_ch    = tbl[i].ch;
            cfg_bus.cfg_div   = tbl[i].div;
            cfg_bus.cfg_phase = tbl[i].phase;
            tick();
            check($sformatf("vec%0d", i),
                  {22'd0, clk_out, clk_en, cfg_bus.cfg_ack, locked},
                  {22'd0, tbl[i].exp_out, tbl[i].exp_en, tbl[i].exp_ack, tbl[i].exp_locked});
        end
        cfg_bus.cfg_we = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 2'd2, 8'd7, 8'd3, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 4'b0001, 4'b0001, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 4'b0110, 4'b0110, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 4'b0101, 4'b0001, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 4'b1010, 4'b1010, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 4'b1001, 4'b0001, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 4'b1110, 4'b0110, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 4'b1101, 4'b0001, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 4'b0010, 4'b0010, 1'b0, 1'b0};

        sys_rst_n = 1'b0;
        cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_ch = 2'd0; cfg_bus.cfg_div = 8'd0; cfg_bus.cfg_phase = 8'd0;
        cfg_bus3.cfg_we = 1'b0; cfg_bus3.cfg_ch = 2'd0; cfg_bus3.cfg_div = 8'd0; cfg_bus3.cfg_phase = 8'd0;
        tick();

        // Power-up waveform, with a write during reset that must be ignored.
        apply_table();
        while (k < 15) tick();
        check("lock_k15", {31'd0, locked}, 32'd0);
        tick();
        check("lock_k16", {31'd0, locked}, 32'd1);
        check("lock3_k16", {31'd0, locked3}, 32'd1);

        // Reconfigure ch2 while locked.
        write_main(2'd2, 8'd3, 8'd2);
        w_edge = k;
        check("A_ack", {30'd0, cfg_bus.cfg_ack, cfg_bus.cfg_err}, 32'd2);
        for (int r = 0; r <= 16; r++) begin
            logic [3:0] e;
            if (r > 0) tick();
            e = exp_init(k);
            e[2] = exp_ch2(r);
            check("A_clk", {28'd0, clk_out}, {28'd0, e});
            check("A_lock", {31'd0, locked}, {31'd0, (r == 16)});
            if (r == 1) check("A_ack_pulse", {31'd0, cfg_bus.cfg_ack}, 32'd0);
        end

        // Out-of-range channel on the 3-channel instance.
        cfg_bus3.cfg_we = 1'b1; cfg_bus3.cfg_ch = 2'd3; cfg_bus3.cfg_div = 8'd5; cfg_bus3.cfg_phase = 8'd0;
        tick();
        cfg_bus3.cfg_we = 1'b0;
        check("E_ack_err", {30'd0, cfg_bus3.cfg_ack, cfg_bus3.cfg_err}, 32'd3);
        check("E_lock", {31'd0, locked3}, 32'd1);
        for (int r = 0; r < 6; r++) begin
            logic [3:0] e;
            if (r > 0) tick();
            e = exp_init(k);
            check("E_clk", {29'd0, clk_out3}, {29'd0, e[2:0]});
            if (r == 1) check("E_pulse", {30'd0, cfg_bus3.cfg_ack, cfg_bus3.cfg_err}, 32'd0);
        end

        // Disable ch3, then run it at div=1.
        write_main(2'd3, 8'd0, 8'd0);
        for (int r = 0; r < 10; r++) begin
            logic [3:0] e;
            if (r > 0) tick();
            e = exp_init(k);
            e[2] = exp_ch2(k - w_edge);
            check("B_off", {28'd0, clk_out[3], clk_en[3], clk_out[1:0]}, {28'd0, 2'b00, e[1:0]});
            check("B_ch2", {31'd0, clk_out[2]}, {31'd0, e[2]});
        end
        write_main(2'd3, 8'd1, 8'd0);
        check("B_restart", {31'd0, clk_out[3]}, 32'd0);
        for (int r = 1; r <= 6; r++) begin
            tick();
            check("B_run", {30'd0, clk_out[3], clk_en[3]}, (r % 2 == 1) ? 32'd3 : 32'd0);
        end

        // Writes during SETTLE restart the lock count.
        write_main(2'd3, 8'd1, 8'd0);
        repeat (10) tick();
        write_main(2'd3, 8'd1, 8'd0);
        repeat (5) tick();
        check("C_lock_mid", {31'd0, locked}, 32'd0);
        write_main(2'd3, 8'd1, 8'd0);
        for (int r = 0; r <= 16; r++) begin
            if (r > 0) tick();
            if (r == 0 || r >= 14) check("C_lock", {31'd0, locked}, {31'd0, (r == 16)});
        end

        // Mid-operation reset with a concurrent write.
        apply_table();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
